// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge pipeline.
// Direction quantisation uses tan(22.5deg) ~ 53/128 and tan(67.5deg) ~ 309/128.
package canny_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MAG_W     = 11;

   localparam int TAN22_NUM     = 53;
   localparam int TAN67_NUM     = 309;
   localparam int TAN_DEN_SHIFT = 7;

   typedef enum logic [1:0] {
      DIR_0   = 2'd0,
      DIR_45  = 2'd1,
      DIR_90  = 2'd2,
      DIR_135 = 2'd3
   } dir_e;

   function automatic logic [7:0] sat8(input logic [15:0] i_val);
      return (i_val > 16'd255) ? 8'hFF : i_val[7:0];
   endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel operator; pixel k = row*3+col, row 0 is the top line.
// Outputs are signed and span +/-(4*(2^DATA_W-1)).
module sobel_kernel
   import canny_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic [9*DATA_W-1:0]      i_window,
   output logic signed [DATA_W+2:0] o_gx,
   output logic signed [DATA_W+2:0] o_gy
);

   localparam int GW = DATA_W + 3;

   logic signed [GW-1:0] w_p [9];

   always_comb begin
      for (int k = 0; k < 9; k++) begin
         w_p[k] = signed'({3'b000, i_window[k*DATA_W +: DATA_W]});
      end
   end

   // Partial sums peak at 4*max_pixel, which still fits the signed GW range.
   assign o_gx = (w_p[2] + (w_p[5] <<< 1) + w_p[8]) - (w_p[0] + (w_p[3] <<< 1) + w_p[6]);
   assign o_gy = (w_p[6] + (w_p[7] <<< 1) + w_p[8]) - (w_p[0] + (w_p[1] <<< 1) + w_p[2]);

endmodule

// File: rtl/gradient_calc.sv
// Two-stage Sobel gradient: stage 1 registers |Gx|,|Gy| and signs, stage 2 magnitude/direction.
// Define GRAD_XY_OUT_EN to drive the saturated |Gx|/|Gy| debug outputs and pixel_xy_valid.
module gradient_calc
   import canny_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int MAG_W  = DEF_MAG_W
)(
   input  logic                clk,
   input  logic                rstN,
   input  logic [9*DATA_W-1:0] gradient_data_in,
   input  logic                gradient_data_in_valid,
   output logic [MAG_W-1:0]    gradient_magnitude,
   output logic [1:0]          gradient_direction,
   output logic                gradient_out_valid,
   output logic [DATA_W-1:0]   pixel_out,
   output logic [DATA_W-1:0]   pixel_out_x,
   output logic [DATA_W-1:0]   pixel_out_y,
   output logic                pixel_xy_valid
);

   localparam int GW = DATA_W + 3;
   localparam int AW = DATA_W + 2;
   localparam int CW = AW + 10;

   logic signed [GW-1:0] w_gx;
   logic signed [GW-1:0] w_gy;
   logic [AW-1:0]        w_abs_gx;
   logic [AW-1:0]        w_abs_gy;
   logic [AW-1:0]        r_abs_gx;
   logic [AW-1:0]        r_abs_gy;
   logic                 r_sign_gx;
   logic                 r_sign_gy;
   logic                 r_s1_valid;
   logic [CW-1:0]        w_gy_scaled;
   logic [CW-1:0]        w_gx_tan22;
   logic [CW-1:0]        w_gx_tan67;
   logic [MAG_W-1:0]     w_mag;
   dir_e                 w_dir;

   sobel_kernel #(.DATA_W(DATA_W)) u_sobel (
      .i_window (gradient_data_in),
      .o_gx     (w_gx),
      .o_gy     (w_gy)
   );

   assign w_abs_gx = w_gx[GW-1] ? AW'(-w_gx) : AW'(w_gx);
   assign w_abs_gy = w_gy[GW-1] ? AW'(-w_gy) : AW'(w_gy);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_s1_valid <= 1'b0;
         r_abs_gx   <= '0;
         r_abs_gy   <= '0;
         r_sign_gx  <= 1'b0;
         r_sign_gy  <= 1'b0;
      end else begin
         r_s1_valid <= gradient_data_in_valid;
         if (gradient_data_in_valid) begin
            r_abs_gx  <= w_abs_gx;
            r_abs_gy  <= w_abs_gy;
            r_sign_gx <= w_gx[GW-1];
            r_sign_gy <= w_gy[GW-1];
         end
      end
   end

   // Angle bins by cross-multiplication: compare 128*|Gy| against tan*128*|Gx|.
   assign w_gy_scaled = CW'(r_abs_gy) << TAN_DEN_SHIFT;
   assign w_gx_tan22  = CW'(r_abs_gx) * CW'(TAN22_NUM);
   assign w_gx_tan67  = CW'(r_abs_gx) * CW'(TAN67_NUM);
   assign w_mag       = MAG_W'(r_abs_gx) + MAG_W'(r_abs_gy);

   always_comb begin
      if (w_gy_scaled <= w_gx_tan22) begin
         w_dir = DIR_0;
      end else if (w_gy_scaled >= w_gx_tan67) begin
         w_dir = DIR_90;
      end else if (r_sign_gx == r_sign_gy) begin
         w_dir = DIR_45;
      end else begin
         w_dir = DIR_135;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         gradient_out_valid <= 1'b0;
         gradient_magnitude <= '0;
         gradient_direction <= 2'd0;
         pixel_out          <= '0;
      end else begin
         gradient_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            gradient_magnitude <= w_mag;
            gradient_direction <= w_dir;
            pixel_out          <= DATA_W'(sat8(16'(w_mag)));
         end
      end
   end

`ifdef GRAD_XY_OUT_EN
   logic [DATA_W-1:0] r_pix_x;
   logic [DATA_W-1:0] r_pix_y;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_pix_x <= '0;
         r_pix_y <= '0;
      end else if (gradient_data_in_valid) begin
         r_pix_x <= DATA_W'(sat8(16'(w_abs_gx)));
         r_pix_y <= DATA_W'(sat8(16'(w_abs_gy)));
      end
   end

   assign pixel_out_x    = r_pix_x;
   assign pixel_out_y    = r_pix_y;
   assign pixel_xy_valid = r_s1_valid;
`else
   assign pixel_out_x    = '0;
   assign pixel_out_y    = '0;
   assign pixel_xy_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gradient_calc.sv
// Self-checking bench for gradient_calc: directed Sobel patterns, valid-gap stream,
// randomized windows against a behavioural model, and mid-stream asynchronous reset.
`timescale 1ns/1ps
module tb_gradient_calc;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [71:0] gradient_data_in = '0;
   logic        gradient_data_in_valid = 1'b0;
   logic [10:0] gradient_magnitude;
   logic [1:0]  gradient_direction;
   logic        gradient_out_valid;
   logic [7:0]  pixel_out;
   logic [7:0]  pixel_out_x;
   logic [7:0]  pixel_out_y;
   logic        pixel_xy_valid;

   gradient_calc dut (
      .clk                    (clk),
      .rstN                   (rstN),
      .gradient_data_in       (gradient_data_in),
      .gradient_data_in_valid (gradient_data_in_valid),
      .gradient_magnitude     (gradient_magnitude),
      .gradient_direction     (gradient_direction),
      .gradient_out_valid     (gradient_out_valid),
      .pixel_out              (pixel_out),
      .pixel_out_x            (pixel_out_x),
      .pixel_out_y            (pixel_out_y),
      .pixel_xy_valid         (pixel_xy_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int step     = 0;
   int base     = 0;
   bit h_v  [4096];
   int h_gx [4096];
   int h_gy [4096];

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic void sobel_ref(input logic [71:0] w, output int gx, output int gy);
      int p[9];
      for (int k = 0; k < 9; k++) p[k] = int'(w[8*k +: 8]);
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
   endfunction

   function automatic int dir_ref(input int gx, input int gy);
      int ax = iabs(gx);
      int ay = iabs(gy);
      if (128*ay <= 53*ax) return 0;
      if (128*ay >= 309*ax) return 2;
      return ((gx > 0) == (gy > 0)) ? 1 : 3;
   endfunction

   function automatic int last_valid(input int upto);
      for (int i = upto; i >= base; i--) if (h_v[i]) return i;
      return -1;
   endfunction

   // Output at a sample point reflects the newest valid window at least 1 (x/y) or 2 (mag) cycles old.
   function automatic void model(output int exyv, output int ex, output int ey,
                                 output int eov, output int em, output int ed, output int ep);
      int i1 = last_valid(step - 1);
      int i2 = last_valid(step - 2);
`ifdef GRAD_XY_OUT_EN
      exyv = (step - 1 >= base) ? int'(h_v[step-1]) : 0;
      ex   = (i1 < 0) ? 0 : sat(iabs(h_gx[i1]));
      ey   = (i1 < 0) ? 0 : sat(iabs(h_gy[i1]));
`else
      exyv = (i1 < -1) ? 1 : 0;
      ex   = 0;
      ey   = 0;
`endif
      eov = (step - 2 >= base) ? int'(h_v[step-2]) : 0;
      em  = (i2 < 0) ? 0 : iabs(h_gx[i2]) + iabs(h_gy[i2]);
      ed  = (i2 < 0) ? 0 : dir_ref(h_gx[i2], h_gy[i2]);
      ep  = sat(em);
   endfunction

   task automatic drive(input logic [71:0] w, input logic v);
      int gx, gy;
      gradient_data_in       = w;
      gradient_data_in_valid = v;
      sobel_ref(w, gx, gy);
      h_v[step]  = v;
      h_gx[step] = gx;
      h_gy[step] = gy;
      @(posedge clk);
      @(negedge clk);
      step++;
   endtask

   function automatic logic [71:0] rand_window(input int mode);
      logic [71:0] w = '0;
      int a, b;
      case (mode)
         0: for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
         1: for (int k = 0; k < 9; k++) w[8*k +: 8] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
         default: begin
            // Gx = +/-2a, Gy = +/-2b with b placed right at a tan boundary
            if ($urandom_range(0, 1) == 1) begin
               a = $urandom_range(1, 255);
               b = (53*a)/128 + $urandom_range(0, 2) - 1;
            end else begin
               a = $urandom_range(1, 105);
               b = (309*a)/128 + $urandom_range(0, 2) - 1;
            end
            if (b < 0) b = 0;
            if (b > 255) b = 255;
            if ($urandom_range(0, 1) == 1) w[8*5 +: 8] = 8'(a); else w[8*3 +: 8] = 8'(a);
            if ($urandom_range(0, 1) == 1) w[8*7 +: 8] = 8'(b); else w[8*1 +: 8] = 8'(b);
         end
      endcase
      return w;
   endfunction

   task automatic test_reset();
      rstN = 1'b0;
      gradient_data_in = '0;
      gradient_data_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (gradient_magnitude !== 11'd0) begin n_err++; $display("FAIL reset mag got=%0d exp=0", gradient_magnitude); end
      n_checks++; if (gradient_direction !== 2'd0) begin n_err++; $display("FAIL reset dir got=%0d exp=0", gradient_direction); end
      n_checks++; if (gradient_out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got=%0b exp=0", gradient_out_valid); end
      n_checks++; if (pixel_out !== 8'd0) begin n_err++; $display("FAIL reset pixel_out got=%0d exp=0", pixel_out); end
      n_checks++; if (pixel_out_x !== 8'd0) begin n_err++; $display("FAIL reset pixel_x got=%0d exp=0", pixel_out_x); end
      n_checks++; if (pixel_out_y !== 8'd0) begin n_err++; $display("FAIL reset pixel_y got=%0d exp=0", pixel_out_y); end
      n_checks++; if (pixel_xy_valid !== 1'b0) begin n_err++; $display("FAIL reset xy_valid got=%0b exp=0", pixel_xy_valid); end
      rstN = 1'b1;
      base = step;
      drive('0, 1'b0);
      n_checks++; if (gradient_out_valid !== 1'b0) begin n_err++; $display("FAIL reset idle out_valid got=%0b exp=0", gradient_out_valid); end
      n_checks++; if (pixel_xy_valid !== 1'b0) begin n_err++; $display("FAIL reset idle xy_valid got=%0b exp=0", pixel_xy_valid); end
   endtask

   task automatic test_patterns();
      logic [71:0] win [6];
      int t_mag [6] = '{0, 1020, 1020, 510, 510, 80};
      int t_dir [6] = '{0, 0, 2, 1, 3, 3};
      int t_pix [6] = '{0, 255, 255, 255, 255, 80};
      int t_x   [6] = '{0, 255, 0, 255, 255, 40};
      int t_y   [6] = '{0, 0, 255, 255, 255, 40};
      int ex, ey, exyv;
      for (int k = 0; k < 9; k++) begin
         int r = k / 3;
         int c = k % 3;
         win[0][8*k +: 8] = 8'd100;
         win[1][8*k +: 8] = (c == 0) ? 8'd0 : (c == 1) ? 8'd128 : 8'd255;
         win[2][8*k +: 8] = (r == 0) ? 8'd0 : (r == 1) ? 8'd128 : 8'd255;
      end
      win[3] = '0; win[3][71:64] = 8'd255;
      win[4] = '0; win[4][55:48] = 8'd255;
      win[5] = '0; win[5][23:16] = 8'd40;
      for (int i = 0; i < 6; i++) begin
`ifdef GRAD_XY_OUT_EN
         ex = t_x[i]; ey = t_y[i]; exyv = 1;
`else
         ex = 0; ey = 0; exyv = 0;
`endif
         drive(win[i], 1'b1);
         n_checks++; if (pixel_xy_valid !== 1'(exyv)) begin n_err++; $display("FAIL pat%0d xy_valid got=%0b exp=%0d", i, pixel_xy_valid, exyv); end
         n_checks++; if (pixel_out_x !== 8'(ex)) begin n_err++; $display("FAIL pat%0d pixel_x got=%0d exp=%0d", i, pixel_out_x, ex); end
         n_checks++; if (pixel_out_y !== 8'(ey)) begin n_err++; $display("FAIL pat%0d pixel_y got=%0d exp=%0d", i, pixel_out_y, ey); end
         n_checks++; if (gradient_out_valid !== 1'b0) begin n_err++; $display("FAIL pat%0d early out_valid got=%0b exp=0", i, gradient_out_valid); end
         drive(rand_window(0), 1'b0);
         n_checks++; if (gradient_out_valid !== 1'b1) begin n_err++; $display("FAIL pat%0d out_valid got=%0b exp=1", i, gradient_out_valid); end
         n_checks++; if (gradient_magnitude !== 11'(t_mag[i])) begin n_err++; $display("FAIL pat%0d mag got=%0d exp=%0d", i, gradient_magnitude, t_mag[i]); end
         n_checks++; if (gradient_direction !== 2'(t_dir[i])) begin n_err++; $display("FAIL pat%0d dir got=%0d exp=%0d", i, gradient_direction, t_dir[i]); end
         n_checks++; if (pixel_out !== 8'(t_pix[i])) begin n_err++; $display("FAIL pat%0d pixel_out got=%0d exp=%0d", i, pixel_out, t_pix[i]); end
         n_checks++; if (pixel_xy_valid !== 1'b0) begin n_err++; $display("FAIL pat%0d xy_valid gap got=%0b exp=0", i, pixel_xy_valid); end
         n_checks++; if (pixel_out_x !== 8'(ex)) begin n_err++; $display("FAIL pat%0d pixel_x hold got=%0d exp=%0d", i, pixel_out_x, ex); end
         drive(rand_window(0), 1'b0);
      end
   endtask

   task automatic test_stream();
      bit [3:0] pat = 4'b1011;
      int exyv, ex, ey, eov, em, ed, ep;
      for (int i = 0; i < 15; i++) begin
         drive(rand_window(i % 2), (i < 13) ? pat[i % 4] : 1'b0);
         model(exyv, ex, ey, eov, em, ed, ep);
         n_checks++; if (pixel_xy_valid !== 1'(exyv)) begin n_err++; $display("FAIL stream%0d xy_valid got=%0b exp=%0d", i, pixel_xy_valid, exyv); end
         n_checks++; if (pixel_out_x !== 8'(ex)) begin n_err++; $display("FAIL stream%0d pixel_x got=%0d exp=%0d", i, pixel_out_x, ex); end
         n_checks++; if (pixel_out_y !== 8'(ey)) begin n_err++; $display("FAIL stream%0d pixel_y got=%0d exp=%0d", i, pixel_out_y, ey); end
         n_checks++; if (gradient_out_valid !== 1'(eov)) begin n_err++; $display("FAIL stream%0d out_valid got=%0b exp=%0d", i, gradient_out_valid, eov); end
         n_checks++; if (gradient_magnitude !== 11'(em)) begin n_err++; $display("FAIL stream%0d mag got=%0d exp=%0d", i, gradient_magnitude, em); end
         n_checks++; if (gradient_direction !== 2'(ed)) begin n_err++; $display("FAIL stream%0d dir got=%0d exp=%0d", i, gradient_direction, ed); end
         n_checks++; if (pixel_out !== 8'(ep)) begin n_err++; $display("FAIL stream%0d pixel_out got=%0d exp=%0d", i, pixel_out, ep); end
      end
   endtask

   task automatic test_random();
      int exyv, ex, ey, eov, em, ed, ep;
      for (int i = 0; i < 200; i++) begin
         drive(rand_window($urandom_range(0, 2)), ($urandom_range(0, 3) != 0));
         model(exyv, ex, ey, eov, em, ed, ep);
         n_checks++; if (pixel_xy_valid !== 1'(exyv)) begin n_err++; $display("FAIL rand%0d xy_valid got=%0b exp=%0d", i, pixel_xy_valid, exyv); end
         n_checks++; if (pixel_out_x !== 8'(ex)) begin n_err++; $display("FAIL rand%0d pixel_x got=%0d exp=%0d", i, pixel_out_x, ex); end
         n_checks++; if (pixel_out_y !== 8'(ey)) begin n_err++; $display("FAIL rand%0d pixel_y got=%0d exp=%0d", i, pixel_out_y, ey); end
         n_checks++; if (gradient_out_valid !== 1'(eov)) begin n_err++; $display("FAIL rand%0d out_valid got=%0b exp=%0d", i, gradient_out_valid, eov); end
         n_checks++; if (gradient_magnitude !== 11'(em)) begin n_err++; $display("FAIL rand%0d mag got=%0d exp=%0d", i, gradient_magnitude, em); end
         n_checks++; if (gradient_direction !== 2'(ed)) begin n_err++; $display("FAIL rand%0d dir got=%0d exp=%0d", i, gradient_direction, ed); end
         n_checks++; if (pixel_out !== 8'(ep)) begin n_err++; $display("FAIL rand%0d pixel_out got=%0d exp=%0d", i, pixel_out, ep); end
      end
   endtask

   task automatic test_reset_midstream();
      int exyv, ex, ey, eov, em, ed, ep;
      drive(rand_window(1), 1'b1);
      drive(rand_window(1), 1'b1);
      model(exyv, ex, ey, eov, em, ed, ep);
      n_checks++; if (gradient_out_valid !== 1'(eov)) begin n_err++; $display("FAIL midrst pre out_valid got=%0b exp=%0d", gradient_out_valid, eov); end
      gradient_data_in_valid = 1'b0;
      rstN = 1'b0;
      #1;
      n_checks++; if (gradient_magnitude !== 11'd0) begin n_err++; $display("FAIL midrst mag got=%0d exp=0", gradient_magnitude); end
      n_checks++; if (gradient_direction !== 2'd0) begin n_err++; $display("FAIL midrst dir got=%0d exp=0", gradient_direction); end
      n_checks++; if (gradient_out_valid !== 1'b0) begin n_err++; $display("FAIL midrst out_valid got=%0b exp=0", gradient_out_valid); end
      n_checks++; if (pixel_out !== 8'd0) begin n_err++; $display("FAIL midrst pixel_out got=%0d exp=0", pixel_out); end
      n_checks++; if (pixel_out_x !== 8'd0) begin n_err++; $display("FAIL midrst pixel_x got=%0d exp=0", pixel_out_x); end
      n_checks++; if (pixel_out_y !== 8'd0) begin n_err++; $display("FAIL midrst pixel_y got=%0d exp=0", pixel_out_y); end
      n_checks++; if (pixel_xy_valid !== 1'b0) begin n_err++; $display("FAIL midrst xy_valid got=%0b exp=0", pixel_xy_valid); end
      @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      base = step;
      for (int i = 0; i < 5; i++) begin
         drive(rand_window(0), (i == 3));
         model(exyv, ex, ey, eov, em, ed, ep);
         n_checks++; if (gradient_out_valid !== 1'(eov)) begin n_err++; $display("FAIL midrst post%0d out_valid got=%0b exp=%0d", i, gradient_out_valid, eov); end
         n_checks++; if (pixel_xy_valid !== 1'(exyv)) begin n_err++; $display("FAIL midrst post%0d xy_valid got=%0b exp=%0d", i, pixel_xy_valid, exyv); end
         n_checks++; if (gradient_magnitude !== 11'(em)) begin n_err++; $display("FAIL midrst post%0d mag got=%0d exp=%0d", i, gradient_magnitude, em); end
         n_checks++; if (pixel_out_x !== 8'(ex)) begin n_err++; $display("FAIL midrst post%0d pixel_x got=%0d exp=%0d", i, pixel_out_x, ex); end
      end
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_stream();
      test_random();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
